// File: rtl/pipeline_stall_control_if.sv
// Hazard/branch/multdiv handshake between the decode-stage hazard logic and the
// stall controller; master drives the hazard inputs, slave (the controller) drives enables.
interface pipeline_stall_control_if #(
  parameter int CNT_W = 8
);
  logic             is_data_hazard;
  logic             branch_taken;
  logic             md_start;
  logic             md_ready;
  logic             pc_en;
  logic             fd_en;
  logic             dx_en;
  logic             fd_flush;
  logic             dx_bubble;
  logic             xm_bubble;
  logic [1:0]       ctl_state;
  logic             hazard_timeout;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output is_data_hazard, branch_taken, md_start, md_ready,
    input  pc_en, fd_en, dx_en, fd_flush, dx_bubble, xm_bubble,
    input  ctl_state, hazard_timeout, stall_count
  );

  modport slave (
    input  is_data_hazard, branch_taken, md_start, md_ready,
    output pc_en, fd_en, dx_en, fd_flush, dx_bubble, xm_bubble,
    output ctl_state, hazard_timeout, stall_count
  );
endinterface

// File: rtl/pipeline_stall_control.sv
// Pipeline stall/flush controller for the five-stage latch bank (Mealy outputs).
// Optional stall performance counter enabled by defining STALL_PERF_CNT_EN.
module pipeline_stall_control #(
  parameter int HAZ_MAX = 4,
  parameter int CNT_W   = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  pipeline_stall_control_if.slave  ctl
);

  localparam int RUN_W = $clog2(HAZ_MAX + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HAZ     = 2'd1,
    MD_WAIT = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_nxt;
  logic             timeout_q;
  logic             pc_en;
  logic             fd_en;
  logic             dx_en;
  logic             fd_flush;
  logic             dx_bubble;
  logic             xm_bubble;

  // Priority is branch > md_start > hazard; md_start is not expected while DX is bubbled in HAZ.
  always_comb begin
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    dx_en     = 1'b1;
    fd_flush  = 1'b0;
    dx_bubble = 1'b0;
    xm_bubble = 1'b0;
    state_nxt = state;
    run_nxt   = run_cnt;
    if (reset) begin
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      dx_en     = 1'b0;
      fd_flush  = 1'b1;
      dx_bubble = 1'b1;
      xm_bubble = 1'b1;
      state_nxt = RUN;
      run_nxt   = '0;
    end else begin
      case (state)
        RUN: begin
          if (ctl.branch_taken) begin
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
          end else if (ctl.md_start) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            dx_en     = 1'b0;
            xm_bubble = 1'b1;
            state_nxt = MD_WAIT;
          end else if (ctl.is_data_hazard) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            dx_bubble = 1'b1;
            state_nxt = HAZ;
            run_nxt   = RUN_W'(1);
          end
        end
        HAZ: begin
          if (ctl.branch_taken) begin
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
            state_nxt = RUN;
            run_nxt   = '0;
          end else if (ctl.is_data_hazard) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            dx_bubble = 1'b1;
            if (run_cnt != RUN_W'(HAZ_MAX)) begin
              run_nxt = run_cnt + RUN_W'(1);
            end
          end else begin
            state_nxt = RUN;
            run_nxt   = '0;
          end
        end
        MD_WAIT: begin
          if (ctl.md_ready) begin
            state_nxt = RUN;
          end else begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            dx_en     = 1'b0;
            xm_bubble = 1'b1;
          end
        end
        default: begin
          state_nxt = RUN;
          run_nxt   = '0;
        end
      endcase
    end
  end

  // Timeout is sticky: once the hazard run reaches HAZ_MAX only reset clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RUN;
      run_cnt   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      run_cnt <= run_nxt;
      if (run_nxt == RUN_W'(HAZ_MAX)) begin
        timeout_q <= 1'b1;
      end
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!pc_en && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign ctl.stall_count = stall_cnt;
`else
  assign ctl.stall_count = '0;
`endif

  assign ctl.pc_en          = pc_en;
  assign ctl.fd_en          = fd_en;
  assign ctl.dx_en          = dx_en;
  assign ctl.fd_flush       = fd_flush;
  assign ctl.dx_bubble      = dx_bubble;
  assign ctl.xm_bubble      = xm_bubble;
  assign ctl.ctl_state      = state;
  assign ctl.hazard_timeout = timeout_q;

endmodule

// File: doc/pipeline_stall_control.md
Name: pipeline_stall_control

Overview:
- Consumer end of the decode-stage hazard interface. Takes the hazard flag from the FD-stage hazard detector, branch resolution from X, and the multdiv start/ready handshake.
- Drives the PC and pipeline-latch enables, plus the nop-insertion selects for the FD, DX and XM latches.
- Sits between the hazard/branch logic and the five-stage latch bank in the processor top level.

Parameters:
- HAZ_MAX, 4, consecutive HAZ-state cycles after which hazard_timeout is set.
- CNT_W, 8, width of the stall performance counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- is_data_hazard  in  1  RAW hazard detected for the insn in FD
- branch_taken  in  1  taken branch/jump resolved in X; FD and DX hold wrong-path insns
- md_start  in  1  one-cycle pulse: mult/div in DX begins execution this cycle
- md_ready  in  1  mult/div result valid this cycle
- pc_en  out  1  PC register write enable
- fd_en  out  1  FD latch write enable
- dx_en  out  1  DX latch write enable
- fd_flush  out  1  load nop (32'h0) into FD
- dx_bubble  out  1  load nop into DX
- xm_bubble  out  1  load nop into XM
- ctl_state  out  2  current state: RUN=0, HAZ=1, MD_WAIT=2
- hazard_timeout  out  1  sticky error flag
- stall_count  out  CNT_W  total stall cycles, saturating

Behaviour:
- One clock, reset is synchronous and active-high. All state updates occur on the rising edge of clock.
- Outputs are combinational from the registered state and the current inputs (Mealy), so a stall takes effect in the cycle the hazard is flagged.
- While reset=1: pc_en=fd_en=dx_en=0; fd_flush=dx_bubble=xm_bubble=1.
- On the edge with reset=1: state=RUN, hazard_timeout=0, stall_count=0, HAZ run counter=0. Reset mid-stall abandons the stall with no residual state.
- Defaults, unless overridden below: pc_en=fd_en=dx_en=1; fd_flush=dx_bubble=xm_bubble=0.
- Input priority within a state: branch_taken > md_start > is_data_hazard.
- RUN state:
  - branch_taken=1: fd_flush=1, dx_bubble=1, enables 1; next state RUN.
  - md_start=1: pc_en=fd_en=dx_en=0, xm_bubble=1; next state MD_WAIT.
  - is_data_hazard=1: pc_en=fd_en=0, dx_bubble=1; next state HAZ; run counter=1.
  - Otherwise: defaults; stay in RUN.
- HAZ state:
  - branch_taken=1: flush as in RUN; next state RUN; run counter cleared.
  - is_data_hazard=1: pc_en=fd_en=0, dx_bubble=1; stay in HAZ; run counter increments (saturating).
  - is_data_hazard=0: defaults; next state RUN; run counter cleared.
  - Run counter reaching HAZ_MAX sets hazard_timeout. hazard_timeout stays set until reset; the stall continues regardless.
- MD_WAIT state:
  - md_ready=0: pc_en=fd_en=dx_en=0, xm_bubble=1.
  - md_ready=1: defaults (the result advances to XM); next state RUN.
  - md_ready is sampled only in MD_WAIT. md_ready asserted in the same cycle as md_start is ignored, so minimum multdiv latency is 2 cycles.
  - branch_taken, md_start and is_data_hazard are ignored in MD_WAIT.
- stall_count (see optional feature):
  - Increments by 1 on every cycle with pc_en=0 and reset=0.
  - Saturates at 2^CNT_W-1; no wrap.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- Defined: stall_count is implemented as specified above.
- Undefined: no counter register is instantiated and stall_count is tied to 0. All other behaviour is identical.

Test Plan:
- Reset held 2 cycles, then released with inputs idle -> during reset pc_en=0 and all three nop selects=1; after release ctl_state=0, all enables=1, stall_count=0.
- is_data_hazard high for 2 cycles from RUN -> both cycles pc_en=fd_en=0 and dx_bubble=1; ctl_state=1 then returns to 0; stall_count=2.
- is_data_hazard high for 6 cycles with HAZ_MAX=4 -> hazard_timeout rises when the run counter reaches 4 and stays high after the hazard clears, until reset.
- md_start pulse, md_ready on the 5th cycle after it -> xm_bubble=1 and pc_en=dx_en=0 for 5 cycles; all enables=1 on the md_ready cycle; back to RUN; stall_count=5.
- branch_taken and is_data_hazard together in HAZ -> fd_flush=dx_bubble=1, pc_en=1, next ctl_state=0.
- md_start and branch_taken together in RUN -> flush wins, no MD_WAIT entry. md_ready coincident with md_start -> ignored.
- Compile without STALL_PERF_CNT_EN -> stall_count stays 0 through the hazard scenario.
